reg_file_nxm: RTL

Parametrised multi-register file: NUM_REGS words of DATA_W bits, one synchronous write port, two combinational read ports, and a handshake-driven soft-clear sequencer. It replaces the single fixed 16-bit enable register as the datapath's general-purpose register bank, feeding both ALU operands and taking the writeback result.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_nxm_reg_word.sv | 22 ++
 rtl/reg_file_nxm.sv | 103 ++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types for the reg_file_nxm register bank: soft-clear FSM states and
// the address-width helper used to size address ports.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_nxm_reg_word.sv
// One storage word of the register bank: async active-low reset to RESET_VAL,
// synchronous load enable.
module reg_word #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_nxm.sv
// NUM_REGS x DATA_W register file: one write port, two combinational read ports,
// handshake soft-clear sequencer. Optional write-through forwarding: REG_FILE_BYPASS_EN.
module reg_file_nxm
  import reg_file_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_REGS  = 8,
  parameter int                ZERO_R0   = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = addr_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_err
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic              err_q;
  logic              last;
  logic              wr_ok;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] words [NUM_REGS];

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign last      = (cnt == ADDR_W'(NUM_REGS - 1));
  assign wr_ok     = we && (state == IDLE) && writable(waddr);
  assign load_data = (state == CLEAR) ? RESET_VAL : wdata;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= (state == CLEAR) && we;
      cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
    end
  end

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);
  assign wr_err   = err_q;

  // Each word loads either from the write port (IDLE) or the clear sweep (CLEAR).
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
    logic load;
    assign load = (wr_ok && (waddr == ADDR_W'(gi))) ||
                  ((state == CLEAR) && (cnt == ADDR_W'(gi)));
    reg_word #(
      .DATA_W   (DATA_W),
      .RESET_VAL(RESET_VAL)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .load(load),
      .d   (load_data),
      .q   (words[gi])
    );
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (raddr_a == ADDR_W'(i)) rdata_a = words[i];
      if (raddr_b == ADDR_W'(i)) rdata_b = words[i];
    end
    if (ZERO_R0 != 0) begin
      if (raddr_a == '0) rdata_a = '0;
      if (raddr_b == '0) rdata_b = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_ok && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule
